// File: rtl/freq_chk_pkg.sv
// Shared types and constants for the frequency window checker.
// Lock FSM encoding, datapath widths, time base.
package freq_chk_pkg;

    localparam int FREQ_W    = 32;
    localparam int ERR_CNT_W = 16;
    localparam longint unsigned NS_PER_SEC = 64'd1000000000;

    typedef enum logic {
        UNLOCK = 1'b0,
        LOCK   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/freq_wd_timer.sv
// Stall watchdog: counts idle cycles, restarts on kick, holds at terminal.
// expire_o is high in every terminal cycle that has no kick.
module freq_wd_timer #(
    parameter int unsigned CYC = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic kick_i,
    output logic expire_o
);

    localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [W-1:0] TERM = W'(CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (kick_i) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            expire_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_window_check.sv
// Window check, lock hysteresis and stall watchdog on measured frequency.
// FREQ_WINDOW_HIST_EN adds min/max history outputs.
module freq_window_check
    import freq_chk_pkg::*;
#(
    parameter int SYS_PRD_NS      = 10,
    parameter int LOCK_CNT        = 3,
    parameter int LOSS_CNT        = 2,
    parameter int TIMEOUT_SEC     = 3,
    parameter int TIMEOUT_CYC_OVR = 0
) (
    input  logic                 SYS_CLK_I,
    input  logic                 SYS_RST_I,
    input  logic [FREQ_W-1:0]    FREQ_HZ_I,
    input  logic                 FREQ_VLD_I,
    input  logic [FREQ_W-1:0]    FREQ_MIN_I,
    input  logic [FREQ_W-1:0]    FREQ_MAX_I,
    input  logic                 CLR_I,
`ifdef FREQ_WINDOW_HIST_EN
    output logic [FREQ_W-1:0]    FREQ_MIN_SEEN_O,
    output logic [FREQ_W-1:0]    FREQ_MAX_SEEN_O,
`endif
    output logic                 LOCKED_O,
    output logic                 LOCK_CHG_O,
    output logic                 STALE_O,
    output logic [FREQ_W-1:0]    FREQ_LAST_O,
    output logic [ERR_CNT_W-1:0] ERR_CNT_O
);

    localparam longint unsigned TIMEOUT_CYC_DER =
        64'(TIMEOUT_SEC) * NS_PER_SEC / 64'(SYS_PRD_NS);
    localparam int unsigned TIMEOUT_CYC = (TIMEOUT_CYC_OVR != 0) ?
        32'(TIMEOUT_CYC_OVR) : 32'(TIMEOUT_CYC_DER);
    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

    lock_state_e          state_q, state_d;
    logic [7:0]           in_cnt_q, in_cnt_d;
    logic [7:0]           loss_cnt_q, loss_cnt_d;
    logic                 locked_q, locked_d;
    logic                 lock_chg_q, lock_chg_d;
    logic                 stale_q, stale_d;
    logic [FREQ_W-1:0]    freq_last_q, freq_last_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 in_range;
    logic                 wd_expire;

    freq_wd_timer #(
        .CYC(TIMEOUT_CYC)
    ) u_wd (
        .clk_i   (SYS_CLK_I),
        .rst_i   (SYS_RST_I),
        .kick_i  (FREQ_VLD_I),
        .expire_o(wd_expire)
    );

    assign in_range = (FREQ_HZ_I >= FREQ_MIN_I) && (FREQ_HZ_I <= FREQ_MAX_I);

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        locked_d    = locked_q;
        lock_chg_d  = 1'b0;
        stale_d     = stale_q;
        freq_last_d = freq_last_q;
        // Clear applies before a same-cycle error is counted.
        err_cnt_d   = CLR_I ? '0 : err_cnt_q;
        if (FREQ_VLD_I) begin
            freq_last_d = FREQ_HZ_I;
            stale_d     = 1'b0;
            if (!in_range && (err_cnt_d != '1)) begin
                err_cnt_d = err_cnt_d + 1'b1;
            end
            case (state_q)
                UNLOCK: begin
                    if (!in_range) begin
                        in_cnt_d = '0;
                    end else begin
                        loss_cnt_d = '0;
                        if (in_cnt_q + 8'd1 == LOCK_TGT) begin
                            state_d    = LOCK;
                            locked_d   = 1'b1;
                            lock_chg_d = 1'b1;
                            in_cnt_d   = '0;
                        end else begin
                            in_cnt_d = in_cnt_q + 8'd1;
                        end
                    end
                end
                LOCK: begin
                    if (in_range) begin
                        loss_cnt_d = '0;
                    end else if (loss_cnt_q + 8'd1 == LOSS_TGT) begin
                        state_d    = UNLOCK;
                        locked_d   = 1'b0;
                        lock_chg_d = 1'b1;
                        loss_cnt_d = '0;
                    end else begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
            endcase
        end else if (wd_expire) begin
            stale_d    = 1'b1;
            state_d    = UNLOCK;
            in_cnt_d   = '0;
            loss_cnt_d = '0;
            locked_d   = 1'b0;
            lock_chg_d = (state_q == LOCK);
        end
    end

    always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
        if (SYS_RST_I) begin
            state_q     <= UNLOCK;
            in_cnt_q    <= '0;
            loss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            lock_chg_q  <= 1'b0;
            stale_q     <= 1'b0;
            freq_last_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            locked_q    <= locked_d;
            lock_chg_q  <= lock_chg_d;
            stale_q     <= stale_d;
            freq_last_q <= freq_last_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign LOCKED_O    = locked_q;
    assign LOCK_CHG_O  = lock_chg_q;
    assign STALE_O     = stale_q;
    assign FREQ_LAST_O = freq_last_q;
    assign ERR_CNT_O   = err_cnt_q;

`ifdef FREQ_WINDOW_HIST_EN
    logic [FREQ_W-1:0] min_seen_q, min_seen_d;
    logic [FREQ_W-1:0] max_seen_q, max_seen_d;

    always_comb begin
        min_seen_d = CLR_I ? '1 : min_seen_q;
        max_seen_d = CLR_I ? '0 : max_seen_q;
        if (FREQ_VLD_I) begin
            if (FREQ_HZ_I < min_seen_d) min_seen_d = FREQ_HZ_I;
            if (FREQ_HZ_I > max_seen_d) max_seen_d = FREQ_HZ_I;
        end
    end

    always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
        if (SYS_RST_I) begin
            min_seen_q <= '1;
            max_seen_q <= '0;
        end else begin
            min_seen_q <= min_seen_d;
            max_seen_q <= max_seen_d;
        end
    end

    assign FREQ_MIN_SEEN_O = min_seen_q;
    assign FREQ_MAX_SEEN_O = max_seen_q;
`endif

endmodule
